// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift_pipe two-stage shifter.
// Word-op support is selected with the SHIFT_W_OPS_EN macro in shift_pipe.sv.
package shift_pkg;

  localparam int XLEN   = 64;
  localparam int AMT_W  = $clog2(XLEN);
  localparam int W_BITS = 32;

  typedef enum logic [2:0] {
    SHIFT_SLL  = 3'b000,
    SHIFT_SRL  = 3'b001,
    SHIFT_SRA  = 3'b010,
    SHIFT_SLLW = 3'b011,
    SHIFT_SRLW = 3'b100,
    SHIFT_SRAW = 3'b101
  } shift_op_e;

  // Fields are sized for the widest datapath; narrower builds use the low bits.
  typedef struct packed {
    logic [XLEN-1:0]  operand;
    logic [AMT_W-1:0] amount;
    logic             rev_back;
    logic             invert_back;
    logic             sext32;
    logic             illegal;
  } shift_s1_t;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v,
                                                  input int unsigned n);
    logic [XLEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i < n) r[AMT_W'(i)] = v[AMT_W'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Request/response bundle for shift_pipe.
// Both channels transfer on a clock edge where valid && ready are both high.
interface shift_pipe_if #(
  parameter int N = 64,
  parameter int K = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [N-1:0] in_a;
  logic [K-1:0] in_shamt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_shamt, out_ready,
    input  in_ready, out_valid, out_result, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, out_ready,
    output in_ready, out_valid, out_result, out_illegal
  );
endinterface

// File: rtl/shift_right_core.sv
// Combinational logical right shift with zero fill, one mux level per amount bit.
module shift_right_core #(
  parameter int N = 64,
  localparam int K = $clog2(N)
) (
  input  logic [N-1:0] data,
  input  logic [K-1:0] amount,
  output logic [N-1:0] result
);

  logic [N-1:0] lvl;

  always_comb begin
    lvl = data;
    for (int i = 0; i < K; i++) begin
      if (amount[i]) lvl = lvl >> (1 << i);
    end
  end

  assign result = lvl;

endmodule

// File: rtl/shift_pipe.sv
// Two-stage RV64 shift unit: stage 1 reduces every op to a logical right shift,
// stage 2 shifts and undoes the conditioning. Define SHIFT_W_OPS_EN for SLLW/SRLW/SRAW.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N = 64,
  localparam int K = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  shift_pipe_if.slave bus
);

  if (N < 8 || N > XLEN || (N & (N - 1)) != 0) begin : g_bad_n
    $error("shift_pipe: N must be a power of 2 between 8 and 64");
  end
`ifdef SHIFT_W_OPS_EN
  if (N != 64) begin : g_bad_w
    $error("shift_pipe: word ops need N == 64");
  end
`endif

  function automatic logic [N-1:0] rev_n(input logic [N-1:0] v);
    logic [XLEN-1:0] wide;
    wide = bit_reverse(XLEN'(v), N);
    return wide[N-1:0];
  endfunction

  // Handshake: a side transfers when valid && ready at the edge. The input
  // side is ready when stage 1 is empty or moving into the output register;
  // the output register holds steady while out_valid && !out_ready.
  logic         s1_valid;
  shift_s1_t    s1_q;
  shift_s1_t    s1_d;
  logic         s2_load;
  logic         in_fire;
  logic [N-1:0] a;
  logic [K-1:0] shamt;

  assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = !rst && (!s1_valid || s2_load);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign a            = bus.in_a;
  assign shamt        = bus.in_shamt;

  always_comb begin
    s1_d         = '0;
    s1_d.illegal = 1'b1;
    case (bus.in_op)
      SHIFT_SLL: begin
        s1_d.operand  = XLEN'(rev_n(a));
        s1_d.amount   = AMT_W'(shamt);
        s1_d.rev_back = 1'b1;
        s1_d.illegal  = 1'b0;
      end
      SHIFT_SRL: begin
        s1_d.operand = XLEN'(a);
        s1_d.amount  = AMT_W'(shamt);
        s1_d.illegal = 1'b0;
      end
      SHIFT_SRA: begin
        s1_d.operand     = a[N-1] ? XLEN'(~a) : XLEN'(a);
        s1_d.invert_back = a[N-1];
        s1_d.amount      = AMT_W'(shamt);
        s1_d.illegal     = 1'b0;
      end
`ifdef SHIFT_W_OPS_EN
      SHIFT_SLLW: begin
        s1_d.operand  = rev_n({{(N-W_BITS){1'b0}}, a[W_BITS-1:0]});
        s1_d.amount   = {1'b0, shamt[4:0]};
        s1_d.rev_back = 1'b1;
        s1_d.sext32   = 1'b1;
        s1_d.illegal  = 1'b0;
      end
      SHIFT_SRLW: begin
        s1_d.operand = {{(N-W_BITS){1'b0}}, a[W_BITS-1:0]};
        s1_d.amount  = {1'b0, shamt[4:0]};
        s1_d.sext32  = 1'b1;
        s1_d.illegal = 1'b0;
      end
      SHIFT_SRAW: begin
        // The word sits in the upper half so the +32 bias brings it down to bit 0.
        s1_d.operand     = {a[W_BITS-1:0], {W_BITS{a[W_BITS-1]}}};
        if (a[W_BITS-1]) s1_d.operand = ~s1_d.operand;
        s1_d.invert_back = a[W_BITS-1];
        s1_d.amount      = {1'b0, shamt[4:0]} + AMT_W'(W_BITS);
        s1_d.sext32      = 1'b1;
        s1_d.illegal     = 1'b0;
      end
`endif
      default: s1_d.illegal = 1'b1;
    endcase
  end

  logic [N-1:0] core_out;
  logic [N-1:0] fixed;
  logic [N-1:0] s2_result;
  logic         s2_illegal;

  shift_right_core #(.N(N)) u_core (
    .data   (s1_q.operand[N-1:0]),
    .amount (s1_q.amount[K-1:0]),
    .result (core_out)
  );

  always_comb begin
    fixed = core_out;
    if (s1_q.invert_back) fixed = ~fixed;
    if (s1_q.rev_back)    fixed = rev_n(fixed);
`ifdef SHIFT_W_OPS_EN
    if (s1_q.sext32) fixed[N-1:W_BITS] = {(N-W_BITS){fixed[W_BITS-1]}};
    s2_illegal = s1_q.illegal;
`else
    // A word op cannot be decoded in this build; treat any such slot as illegal.
    s2_illegal = s1_q.illegal || s1_q.sext32;
`endif
    s2_result = s2_illegal ? '0 : fixed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_q            <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_q     <= s1_d;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        bus.out_valid   <= 1'b1;
        bus.out_result  <= s2_result;
        bus.out_illegal <= s2_illegal;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomized checks of shift_pipe against a behavioural shift model.
module tb_shift_pipe;
  import shift_pkg::*;

`ifdef SHIFT_W_OPS_EN
  localparam bit W_EN = 1'b1;
`else
  localparam bit W_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_bp = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [64:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [64:0] held_r = '0;

  shift_pipe_if #(.N(64)) bus ();

  shift_pipe #(.N(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV64 shift semantics stated directly. Result is {illegal, value}.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [5:0] sh);
    logic [31:0] w;
    logic [63:0] r;
    w = '0;
    case (op)
      3'd0: r = a << sh;
      3'd1: r = a >> sh;
      3'd2: r = $signed(a) >>> sh;
      3'd3: w = a[31:0] << sh[4:0];
      3'd4: w = a[31:0] >> sh[4:0];
      3'd5: w = $signed(a[31:0]) >>> sh[4:0];
      default: return {1'b1, 64'h0};
    endcase
    if (op >= 3'd3) begin
      if (!W_EN) return {1'b1, 64'h0};
      r = {{32{w[31]}}, w};
    end
    return {1'b0, r};
  endfunction

  function automatic logic [64:0] wexp(input logic [63:0] v);
    return W_EN ? {1'b0, v} : {1'b1, 64'h0};
  endfunction

  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [5:0] sh,
                      input logic [64:0] exp);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_shamt = sh;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (bus.in_ready) exp_q.push_back(exp);
    else begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      waited++;
      @(posedge clk);
    end
    #1;
    check("drain_left", 65'(exp_q.size()), 65'd0);
  endtask

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: pops on every output transfer and checks stall stability.
  always @(negedge clk) begin
    if (rst) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("stall_valid", 65'(bus.out_valid), 65'd1);
        check("stall_data", {bus.out_illegal, bus.out_result}, held_r);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_out: observed %h expected no result",
                 {bus.out_illegal, bus.out_result});
        end else begin
          check("result", {bus.out_illegal, bus.out_result}, exp_q.pop_front());
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_r = {bus.out_illegal, bus.out_result};
    end
  end

  initial begin
    logic [2:0]  op;
    logic [63:0] a;
    logic [5:0]  sh;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 65'(bus.out_valid), 65'd0);
    check("rst_out_data", {bus.out_illegal, bus.out_result}, 65'd0);
    check("rst_in_ready", 65'(bus.in_ready), 65'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 65'(bus.in_ready), 65'd1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge t, visible after edge t+1.
    send(3'd1, 64'h8000_0000_0000_0001, 6'd63, {1'b0, 64'h1});
    @(negedge clk);
    check("lat_t", 65'(bus.out_valid), 65'd0);
    @(negedge clk);
    check("lat_t1", 65'(bus.out_valid), 65'd1);
    @(posedge clk);
    #1;

    send(3'd2, 64'hF000_0000_0000_0000, 6'd4, {1'b0, 64'hFF00_0000_0000_0000});
    send(3'd0, 64'h1, 6'd63, {1'b0, 64'h8000_0000_0000_0000});
    send(3'd5, 64'h0000_0000_8000_0000, 6'd31, wexp(64'hFFFF_FFFF_FFFF_FFFF));
    send(3'd3, 64'h1, 6'd31, wexp(64'hFFFF_FFFF_8000_0000));
    send(3'd7, 64'hFFFF, 6'd5, {1'b1, 64'h0});
    send(3'd6, 64'h1234, 6'd1, {1'b1, 64'h0});
    for (int i = 0; i < 6; i++) begin
      send(3'(i), 64'h8000_0000_8000_0000, 6'd0,
           (i < 3) ? {1'b0, 64'h8000_0000_8000_0000} : wexp(64'hFFFF_FFFF_8000_0000));
    end
    drain();

    // Backpressure: two accepts fill both stages, then the input stalls.
    bus.out_ready = 1'b0;
    send(3'd1, 64'hF0, 6'd4, {1'b0, 64'hF});
    send(3'd1, 64'h1234, 6'd8, {1'b0, 64'h12});
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd1;
    bus.in_a     = 64'hFF00;
    bus.in_shamt = 6'd8;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 65'(bus.in_ready), 65'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'd1, 64'hFF00, 6'd8, {1'b0, 64'hFF});
    send(3'd1, 64'hABCD_0000, 6'd16, {1'b0, 64'hABCD});
    drain();

    // Reset with both stages full: nothing in flight may surface.
    bus.out_ready = 1'b0;
    send(3'd1, 64'h55, 6'd0, {1'b0, 64'h55});
    send(3'd1, 64'h66, 6'd0, {1'b0, 64'h66});
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 65'(bus.in_ready), 65'd0);
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 65'(bus.out_valid), 65'd0);
    check("mid_rst_in_ready2", 65'(bus.in_ready), 65'd0);
    exp_q.delete();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 65'(bus.in_ready), 65'd1);
    repeat (4) begin
      @(negedge clk);
      check("no_stale", 65'(bus.out_valid), 65'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random output backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       sh = 6'd0;
        1:       sh = 6'd63;
        2:       sh = 6'($urandom_range(31, 32));
        default: sh = 6'($urandom_range(0, 63));
      endcase
      send(op, a, sh, model(op, a, sh));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
